// File: rtl/pgr_uart_tx_ctrl_32bit.sv
// UART transmit controller: accepts one byte per valid/ready handshake and
// serializes start, 8 data bits (LSB first), optional parity and stop bits.
module pgr_uart_tx_ctrl_32bit #(
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int DATA_W = 8;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_W - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [TICK_W-1:0]   tick_cnt, tick_nxt;
  logic [2:0]          bit_cnt, bit_nxt;
  logic [DATA_W-1:0]   data_q, data_nxt;
  logic                tx_nxt, done_nxt;
  logic                xfer, bit_end;

  function automatic logic parity_bit(input logic [DATA_W-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  // tx_ready is registered and high only in IDLE, so the handshake never
  // forms a combinational loop back to the requester.
  assign xfer    = tx_valid & tx_ready;
  assign bit_end = baud_tick && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      data_q   <= '0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      data_q   <= data_nxt;
      tx       <= tx_nxt;
      tx_ready <= (state_nxt == IDLE);
      tx_busy  <= (state_nxt != IDLE);
      tx_done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    data_nxt  = data_q;
    if (state == IDLE) begin
      tick_nxt = '0;
      if (xfer) begin
        state_nxt = START;
        bit_nxt   = '0;
        data_nxt  = tx_data;
      end
    end else if (baud_tick) begin
      tick_nxt = bit_end ? '0 : tick_cnt + 1'b1;
      if (bit_end) begin
        case (state)
          START: begin
            state_nxt = DATA;
            bit_nxt   = '0;
          end
          DATA: begin
            if (bit_cnt == BIT_LAST) begin
              state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
              bit_nxt   = '0;
            end else begin
              bit_nxt = bit_cnt + 1'b1;
            end
          end
          PARITY: begin
            state_nxt = STOP;
            bit_nxt   = '0;
          end
          STOP: begin
            // bit_cnt is reused to count stop bits
            if (bit_cnt == STOP_LAST) begin
              state_nxt = IDLE;
              bit_nxt   = '0;
            end else begin
              bit_nxt = bit_cnt + 1'b1;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    tx_nxt   = 1'b1;
    done_nxt = 1'b0;
    case (state)
      IDLE:   tx_nxt = !xfer;
      START:  tx_nxt = bit_end ? data_q[0] : 1'b0;
      DATA: begin
        if (!bit_end)
          tx_nxt = data_q[bit_cnt];
        else if (bit_cnt != BIT_LAST)
          tx_nxt = data_q[bit_nxt];
        else
          tx_nxt = (PARITY_EN != 0) ? parity_bit(data_q) : 1'b1;
      end
      PARITY: tx_nxt = bit_end ? 1'b1 : parity_bit(data_q);
      STOP:   done_nxt = bit_end && (bit_cnt == STOP_LAST);
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_pgr_uart_tx_ctrl_32bit.sv
// Scoreboard bench: three controller configurations share randomized stimulus;
// expected frames are built from the byte at acceptance and checked on tx_done.
module tb_pgr_uart_tx_ctrl_32bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [2:0] tx_w, ready_w, busy_w, done_w;

  always #5 clk = ~clk;

  pgr_uart_tx_ctrl_32bit #(.OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

  pgr_uart_tx_ctrl_32bit #(.OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

  pgr_uart_tx_ctrl_32bit #(.OVERSAMPLE(3), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

  function automatic int cfg_os(input int i);
    return (i == 2) ? 3 : 16;
  endfunction
  function automatic int cfg_par(input int i);
    return (i != 0) ? 1 : 0;
  endfunction
  function automatic int cfg_odd(input int i);
    return (i == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_stop(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  // Reference frame: bit k of the result is the k-th level on the line.
  function automatic logic [15:0] frame_bits(input int i, input logic [7:0] d, output int n);
    logic [15:0] b;
    b    = 16'hFFFF;
    b[0] = 1'b0;
    for (int k = 0; k < 8; k++) b[k+1] = d[k];
    n = 9;
    if (cfg_par(i) != 0) begin
      b[9] = (cfg_odd(i) != 0) ? ~(^d) : (^d);
      n    = 10;
    end
    n = n + cfg_stop(i);
    return b;
  endfunction

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_b [3][$];
  int          exp_n [3][$];
  bit          in_frame [3];
  bit          hold_ok [3];
  bit          start_pend [3];
  int          ticks [3];
  int          nb [3];
  logic [15:0] acc [3];
  bit          tick_pend = 1'b0;
  bit          rst_pend = 1'b1;
  bit          end_req = 1'b0;
  bit          mon_fin = 1'b0;
  logic [15:0] eb_t;
  int          en_t, os_t;
  int          cyc = 0;

  task automatic chk(input bit ok, input string name, input int i,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s inst%0d actual=%h required=%h", name, i, act, req);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      os_t = cfg_os(i);
      if (rst_pend) begin
        if (in_frame[i]) begin
          void'(exp_b[i].pop_front());
          void'(exp_n[i].pop_front());
        end
        in_frame[i] = 1'b0;
        chk(tx_w[i] && ready_w[i] && !busy_w[i] && !done_w[i], "reset_state", i,
            32'({tx_w[i], ready_w[i], busy_w[i], done_w[i]}), 32'h0000_000C);
      end else if (start_pend[i]) begin
        chk(!tx_w[i] && !ready_w[i] && busy_w[i] && !done_w[i], "frame_start", i,
            32'({tx_w[i], ready_w[i], busy_w[i], done_w[i]}), 32'h0000_0002);
        in_frame[i] = 1'b1;
        ticks[i]    = 0;
        acc[i]      = 16'hFFFF;
        acc[i][0]   = tx_w[i];
        nb[i]       = 1;
        hold_ok[i]  = 1'b1;
      end else if (in_frame[i]) begin
        if (tick_pend) ticks[i]++;
        en_t = exp_n[i][0];
        eb_t = exp_b[i][0];
        if (done_w[i]) begin
          void'(exp_b[i].pop_front());
          void'(exp_n[i].pop_front());
          in_frame[i] = 1'b0;
          chk(nb[i] == en_t && acc[i] == eb_t, "frame_bits", i, 32'(acc[i]), 32'(eb_t));
          chk(ticks[i] == en_t * os_t && hold_ok[i] && tx_w[i] && ready_w[i] && !busy_w[i],
              "frame_end", i, 32'(ticks[i]), 32'(en_t * os_t));
        end else if (ticks[i] >= en_t * os_t) begin
          chk(1'b0, "done_missing", i, 32'(ticks[i]), 32'(en_t * os_t));
          void'(exp_b[i].pop_front());
          void'(exp_n[i].pop_front());
          in_frame[i] = 1'b0;
        end else begin
          if (ready_w[i] || !busy_w[i]) hold_ok[i] = 1'b0;
          if (tick_pend && (ticks[i] % os_t) == 0) begin
            acc[i][nb[i]] = tx_w[i];
            nb[i]++;
          end else if (tx_w[i] != acc[i][nb[i]-1]) begin
            hold_ok[i] = 1'b0;
          end
        end
      end else begin
        chk(tx_w[i] && ready_w[i] && !busy_w[i] && !done_w[i], "idle_state", i,
            32'({tx_w[i], ready_w[i], busy_w[i], done_w[i]}), 32'h0000_000C);
      end
      start_pend[i] = !in_frame[i] && tx_valid && !rst;
      if (start_pend[i]) begin
        eb_t = frame_bits(i, tx_data, en_t);
        exp_b[i].push_back(eb_t);
        exp_n[i].push_back(en_t);
      end
    end
    tick_pend = baud_tick;
    rst_pend  = rst;
    if (end_req && !mon_fin) begin
      for (int i = 0; i < 3; i++)
        chk(!in_frame[i] && exp_n[i].size() == 0, "drain", i, 32'(exp_n[i].size()), 32'd0);
      mon_fin = 1'b1;
    end
  end

  // tmode: 0 every cycle, 1 every 4th, 2 random 1/2, 3 random 1/8
  // vmode: 0 low, 1 held high, 2 random
  task automatic run(input int n, input int tmode, input int vmode, input bit drnd,
                     input logic [7:0] dfix, input bit rres);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      case (tmode)
        0:       baud_tick = 1'b1;
        1:       baud_tick = (cyc % 4 == 0);
        2:       baud_tick = ($urandom_range(0, 1) == 1);
        default: baud_tick = ($urandom_range(0, 7) == 0);
      endcase
      case (vmode)
        0:       tx_valid = 1'b0;
        1:       tx_valid = 1'b1;
        default: tx_valid = ($urandom_range(0, 9) < 3);
      endcase
      tx_data = drnd ? 8'($urandom) : dfix;
      rst     = rres && ($urandom_range(0, 399) == 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    run(40, 2, 0, 1'b1, 8'h00, 1'b0);
    run(200, 0, 1, 1'b0, 8'h55, 1'b0);
    run(200, 0, 1, 1'b0, 8'hA5, 1'b0);
    run(200, 0, 1, 1'b0, 8'h0F, 1'b0);
    run(200, 0, 1, 1'b0, 8'h03, 1'b0);
    run(1500, 1, 1, 1'b1, 8'h00, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; tx_valid = 1'b0; baud_tick = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; tx_valid = 1'b1; tx_data = 8'h3C;
    run(69, 0, 0, 1'b0, 8'h3C, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; tx_valid = 1'b1; tx_data = 8'hC3;
    run(300, 0, 0, 1'b0, 8'h5A, 1'b0);
    run(6000, 2, 2, 1'b1, 8'h00, 1'b1);
    run(3000, 3, 2, 1'b1, 8'h00, 1'b1);
    run(300, 0, 0, 1'b0, 8'h00, 1'b0);
    end_req = 1'b1;
    for (int k = 0; k < 20 && !mon_fin; k++) @(posedge clk);
    if (!mon_fin) begin
      $display("FAIL drain_timeout actual=0 required=1");
      $fatal(1, "monitor did not complete");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pgr_uart_tx_ctrl_32bit.md
PGR_UART_TX_CTRL_32BIT -- requirements
Module: pgr_uart_tx_ctrl_32bit

Interface
REQ-001 Parameter OVERSAMPLE, default 16, SHALL set the number of baud_tick pulses per serial bit; legal range is 2..64.
REQ-002 Parameter PARITY_EN, default 0, SHALL insert a parity bit after the data bits when set to 1.
REQ-003 Parameter PARITY_ODD, default 0, SHALL select parity type: 0 = even, 1 = odd; it is ignored when PARITY_EN = 0.
REQ-004 Parameter STOP_BITS, default 1, SHALL set the number of stop bits; legal values are 1 and 2.
REQ-005 clk input 1: the single system clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst input 1: synchronous, active-high reset.
REQ-007 baud_tick input 1: single-cycle clock-enable pulse from the baud divider, at OVERSAMPLE x the baud rate.
REQ-008 tx_data input 8: byte to transmit.
REQ-009 tx_valid input 1: the requester has a byte ready.
REQ-010 tx_ready output 1: the controller can accept a byte.
REQ-011 tx output 1: serial line; idles high.
REQ-012 tx_busy output 1: a frame is in progress.
REQ-013 tx_done output 1: one-cycle pulse marking the end of a frame.

Function
REQ-014 Transfer SHALL occur on a rising clk edge where tx_valid = 1 and tx_ready = 1; tx_data SHALL be latched on that edge.
REQ-015 tx_ready SHALL be a registered output, equal to 1 only in IDLE, and SHALL not depend combinationally on tx_valid.
REQ-016 The state machine SHALL have states IDLE, START, DATA, PARITY and STOP.
- IDLE -> START on transfer.
- START -> DATA at the end of the bit.
- DATA -> PARITY (PARITY_EN = 1) or STOP (PARITY_EN = 0) after bit 7.
- PARITY -> STOP at the end of the bit.
- STOP -> IDLE after STOP_BITS stop bits.
REQ-017 On the transfer edge, tx SHALL be driven to 0 (start bit), the tick counter SHALL clear to 0, and the bit counter SHALL clear to 0.
REQ-018 Tick counter behaviour:
- It SHALL increment only on edges where baud_tick = 1.
- A bit SHALL end on the edge where baud_tick = 1 and tick_cnt = OVERSAMPLE-1.
- The counter SHALL then wrap to 0.
- Every bit SHALL last exactly OVERSAMPLE baud_tick pulses.
REQ-019 Data bits SHALL be sent LSB first; bit counter range is 0..7.
REQ-020 The parity bit SHALL be the XOR of the 8 latched bits, inverted when PARITY_ODD = 1.
REQ-021 tx SHALL be 1 during STOP and IDLE.
REQ-022 On the edge that ends the final stop bit:
- the state SHALL move to IDLE;
- tx_ready SHALL become 1;
- tx_busy SHALL become 0;
- tx_done SHALL pulse high for exactly one cycle.
REQ-023 tx_busy SHALL be 1 in every state except IDLE.
REQ-024 baud_tick pulses in IDLE SHALL be ignored and SHALL leave the tick counter at 0.
REQ-025 tx_valid held high across the end of a frame SHALL be accepted on the first edge after tx_ready becomes 1; the idle gap between frames is therefore at least one clk cycle.
REQ-026 tx_data and tx_valid changes while tx_ready = 0 SHALL have no effect on the frame in progress.
REQ-027 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-028 While rst = 1, on every rising clk edge:
- state = IDLE;
- tx = 1;
- tx_ready = 1;
- tx_busy = 0;
- tx_done = 0;
- tick and bit counters = 0;
- latched data = 0.
REQ-029 rst asserted mid-frame SHALL abort the frame and return tx to 1 on the next rising edge; no tx_done pulse SHALL be produced for the aborted frame.
REQ-030 rst SHALL take priority over a simultaneous transfer, and the byte SHALL not be latched.

Verification
REQ-031 Basic frame: OVERSAMPLE = 16, parity off, 1 stop bit, baud_tick = 1 every cycle, send 0x55.
- tx sequence: 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles.
- tx_done pulses 160 cycles after the transfer edge.
- tx_ready returns to 1 on that same edge.
REQ-032 Parity: PARITY_EN = 1, send 0x03.
- Even parity: parity bit = 0.
- PARITY_ODD = 1: parity bit = 1.
- Frame length is 11 bits = 176 cycles with tick every cycle.
REQ-033 Sparse ticks: baud_tick every 4th cycle, OVERSAMPLE = 16, STOP_BITS = 2.
- Each bit lasts 64 cycles.
- The frame ends after 11 bits.
- tx holds each level exactly 64 cycles.
REQ-034 Back-to-back: tx_valid held high with 0xA5 then 0x0F.
- The second transfer occurs exactly 1 cycle after the first tx_done.
- Both bytes are serialized correctly.
- tx is high for exactly 1 cycle between the frames.
REQ-035 Mid-frame reset: rst pulsed for 1 cycle during DATA bit 3.
- Next edge: tx = 1, tx_ready = 1, tx_busy = 0.
- No tx_done pulse occurs.
- A following byte 0xC3 is then sent correctly.
REQ-036 Idle and stall:
- baud_tick toggling in IDLE with tx_valid = 0 leaves tx = 1 and the counters at 0.
- tx_data changing mid-frame does not alter the transmitted bits.
